// File: rtl/data_memory_unit.sv
// Data-side load/store responder: little-endian byte/halfword/word accesses on a word RAM,
// with a registered, sign/zero-extended read port and misalignment/range error reporting.
`timescale 1ns/1ps
module data_memory_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORD_ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] memoryAddress,
  input  logic [DATA_WIDTH-1:0] memoryDataWrite,
  input  logic [1:0]            memoryLength,
  input  logic                  store,
  input  logic                  load,
  input  logic                  loadUnsigned,
  output logic [DATA_WIDTH-1:0] memoryDataRead,
  output logic                  accessError,
  output logic                  errorSticky
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << WORD_ADDR_WIDTH;

  typedef enum logic {IDLE, RESP} state_e;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [WORD_ADDR_WIDTH-1:0] idx;
  logic [1:0]                 off;
  logic                       strobe, out_of_range, acc_err;
  logic [NB-1:0]              be_d;
  logic [DATA_WIDTH-1:0]      wdata_d;

  state_e                     state_q;
  logic                       err_q, sticky_q, uns_q;
  logic [1:0]                 off_q, len_q;
  logic [DATA_WIDTH-1:0]      rd_word_q;

  function automatic logic [DATA_WIDTH-1:0] lane_extend(
    input logic [DATA_WIDTH-1:0] w,
    input logic [1:0]            o,
    input logic [1:0]            l,
    input logic                  u
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = w[{o[1], 4'b0000} +: 16];
    case (l)
      2'd0:    return {{(DATA_WIDTH-8){~u & b[7]}}, b};
      2'd1:    return {{(DATA_WIDTH-16){~u & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign idx          = memoryAddress[WORD_ADDR_WIDTH+1:2];
  assign off          = memoryAddress[1:0];
  assign strobe       = store | load;
  assign out_of_range = |(memoryAddress >> (WORD_ADDR_WIDTH + 2));

  always_comb begin
    acc_err = out_of_range || (store && load) || (memoryLength == 2'd3) ||
              (memoryLength == 2'd1 && off[0]) ||
              (memoryLength == 2'd2 && off != 2'd0);
  end

  // Byte-lane enables with the store data replicated so every lane sees its bytes.
  always_comb begin
    be_d    = '0;
    wdata_d = memoryDataWrite;
    case (memoryLength)
      2'd0: begin
        be_d[off] = 1'b1;
        wdata_d   = {NB{memoryDataWrite[7:0]}};
      end
      2'd1: begin
        be_d[{off[1], 1'b0}] = 1'b1;
        be_d[{off[1], 1'b1}] = 1'b1;
        wdata_d              = {(NB/2){memoryDataWrite[15:0]}};
      end
      2'd2:    be_d = '1;
      default: be_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store && !acc_err) begin
      for (int b = 0; b < NB; b++) begin
        if (be_d[b]) mem[idx][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  // Strobe cycle -> response cycle: capture RAM word and lane controls, raise error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      rd_word_q <= '0;
      off_q     <= 2'd0;
      len_q     <= 2'd0;
      uns_q     <= 1'b0;
    end else begin
      state_q <= strobe ? RESP : IDLE;
      err_q   <= strobe && acc_err;
      if (strobe && acc_err) sticky_q <= 1'b1;
      if (load) begin
        // A faulted load returns a full-word zero.
        rd_word_q <= acc_err ? '0 : mem[idx];
        off_q     <= off;
        len_q     <= acc_err ? 2'd2 : memoryLength;
        uns_q     <= loadUnsigned;
      end
    end
  end

  assign accessError    = (state_q == RESP) && err_q;
  assign errorSticky    = sticky_q;
  assign memoryDataRead = lane_extend(rd_word_q, off_q, len_q, uns_q);

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: a byte-array reference model queues expected
// responses at issue time; a monitor pops them one cycle after each strobe.
`timescale 1ns/1ps
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memoryAddress, memoryDataWrite, memoryDataRead;
  logic [1:0]  memoryLength;
  logic        store, load, loadUnsigned, accessError, errorSticky;

  data_memory_unit #(.DATA_WIDTH(32), .WORD_ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .memoryAddress(memoryAddress),
    .memoryDataWrite(memoryDataWrite), .memoryLength(memoryLength),
    .store(store), .load(load), .loadUnsigned(loadUnsigned),
    .memoryDataRead(memoryDataRead), .accessError(accessError),
    .errorSticky(errorSticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        sticky;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem_m [4096];
  logic [31:0] last_m;
  logic        sticky_m;
  int          nvec, nmis;
  logic        pend;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, little-endian assembly, explicit extension rules.
  task automatic issue(input logic st, input logic ld, input logic [31:0] a,
                       input logic [1:0] len, input logic uns, input logic [31:0] d);
    logic        e;
    logic [31:0] v;
    int          nb;
    e  = (len == 2'd3) || (len == 2'd1 && a[0]) || (len == 2'd2 && a[1:0] != 2'd0) ||
         (a > 32'h0000_0FFF) || (st && ld);
    nb = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    if (e) begin
      sticky_m = 1'b1;
      if (ld) last_m = 32'd0;
    end else if (st) begin
      for (int i = 0; i < nb; i++) mem_m[a[11:0] + i] = d[8*i +: 8];
    end else if (ld) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[a[11:0] + i];
      if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      last_m = v;
    end
    if (st || ld) q.push_back('{last_m, e, sticky_m});
    store = st; load = ld; memoryAddress = a; memoryLength = len;
    loadUnsigned = uns; memoryDataWrite = d;
    @(posedge clk); #1;
    store = 1'b0; load = 1'b0;
  endtask

  always @(posedge clk) pend = !reset && (store || load);

  always @(negedge clk) begin
    exp_t x;
    if (pend) begin
      if (q.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL scoreboard_underflow: response with no expectation");
      end else begin
        x = q.pop_front();
        chk("read_data", memoryDataRead, x.data);
        chk("access_error", {31'd0, accessError}, {31'd0, x.err});
        chk("error_sticky", {31'd0, errorSticky}, {31'd0, x.sticky});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nvec = 0; nmis = 0; sticky_m = 1'b0; last_m = 32'd0;
    for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
    reset = 1'b1; store = 1'b0; load = 1'b0; loadUnsigned = 1'b0;
    memoryAddress = 32'd0; memoryDataWrite = 32'd0; memoryLength = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", memoryDataRead, 32'd0);
    chk("reset_error", {31'd0, accessError}, 32'd0);
    chk("reset_sticky", {31'd0, errorSticky}, 32'd0);
    reset = 1'b0;

    // Preload a 256-byte window so every later load hits known contents.
    for (int w = 0; w < 64; w++) issue(1'b1, 1'b0, 32'(w * 4), 2'd2, 1'b0, $urandom);

    issue(1, 0, 32'h10, 2'd2, 0, 32'hDEADBEEF);
    issue(0, 1, 32'h10, 2'd2, 0, 32'h0);
    issue(0, 1, 32'h11, 2'd0, 0, 32'h0);
    issue(0, 1, 32'h11, 2'd0, 1, 32'h0);
    issue(0, 1, 32'h12, 2'd1, 0, 32'h0);
    issue(0, 1, 32'h12, 2'd1, 1, 32'h0);
    issue(1, 0, 32'h13, 2'd0, 0, 32'h55);
    issue(0, 1, 32'h10, 2'd2, 0, 32'h0);
    issue(1, 0, 32'h10, 2'd1, 0, 32'h1234);
    issue(0, 1, 32'h10, 2'd2, 0, 32'h0);
    @(posedge clk); #1;
    issue(0, 1, 32'h12, 2'd2, 0, 32'h0);
    issue(1, 0, 32'h11, 2'd1, 0, 32'hFFFF);
    issue(0, 1, 32'h10, 2'd2, 0, 32'h0);
    issue(0, 1, 32'h1000, 2'd2, 0, 32'h0);
    issue(1, 1, 32'h10, 2'd2, 0, 32'h0);
    issue(0, 1, 32'h10, 2'd2, 0, 32'h0);

    // Asynchronous reset landing between a load strobe and its result.
    q.push_back('{32'd0, 1'b0, 1'b0});
    load = 1'b1; memoryAddress = 32'h10; memoryLength = 2'd2;
    @(posedge clk); #2;
    reset = 1'b1; load = 1'b0; sticky_m = 1'b0; last_m = 32'd0;
    #1;
    chk("midreset_data", memoryDataRead, 32'd0);
    chk("midreset_sticky", {31'd0, errorSticky}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(0, 1, 32'h10, 2'd2, 0, 32'h0);

    issue(1, 0, 32'h14, 2'd2, 0, 32'hCAFEF00D);
    issue(1, 0, 32'h18, 2'd2, 0, 32'h0BADC0DE);
    issue(0, 1, 32'h10, 2'd2, 0, 32'h0);
    issue(0, 1, 32'h14, 2'd2, 0, 32'h0);
    issue(0, 1, 32'h18, 2'd2, 0, 32'h0);
    issue(1, 0, 32'h14, 2'd2, 0, 32'h13572468);
    issue(0, 1, 32'h14, 2'd2, 0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 9) == 0) ? ((32'($urandom_range(1, 15)) << 12) | 32'($urandom_range(0, 255)))
                                        : 32'($urandom_range(0, 255));
      if (op == 0) begin
        @(posedge clk); #1;
      end else begin
        issue(op == 9 || op <= 4, op >= 5, a, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
